// File: rtl/keypad_scan_decoder.sv
// -----------------------------------------------------------------------------
// keypad_scan_decoder
//
// Scans an N_ROWS x N_COLS matrix keypad by driving one column low at a time
// and reading the pulled-up row lines. A single pressed key is debounced on
// both press and release. An accepted press reports its index
// (row*N_COLS + col) together with a one-cycle key_valid pulse. Two or more
// rows active in one column slot are reported as a multi_err pulse and are
// otherwise ignored.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   rows       in   [N_ROWS] raw keypad rows, active low, asynchronous
//   cols       out  [N_COLS] column drive, active-low one-hot, registered
//   key_code   out  [KEY_W]  index of the last accepted key
//   key_valid  out  one-cycle pulse when a press is accepted
//   key_held   out  high from press acceptance until release acceptance
//   multi_err  out  one-cycle pulse when a column slot shows >1 active row
// -----------------------------------------------------------------------------
module keypad_scan_decoder #(
   parameter int  N_ROWS     = 4,
   parameter int  N_COLS     = 4,
   parameter int  SCAN_DIV   = 4,
   parameter int  DEB_CYCLES = 8,
   localparam int KEY_W      = $clog2(N_ROWS * N_COLS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_ROWS-1:0] rows,
   output logic [N_COLS-1:0] cols,
   output logic [KEY_W-1:0]  key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              multi_err
);

   localparam int ROW_W = $clog2(N_ROWS);
   localparam int COL_W = $clog2(N_COLS);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------

   // Debounce counter increment that sticks at DEB_CYCLES instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_W'(DEB_CYCLES)) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   function automatic int popcount(input logic [N_ROWS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < N_ROWS; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

   // Index of the set bit; only meaningful when exactly one bit is set.
   function automatic logic [ROW_W-1:0] onehot_idx(input logic [N_ROWS-1:0] v);
      logic [ROW_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_ROWS; i++) begin
         if (v[i]) begin
            idx = ROW_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [N_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
      logic [N_ROWS-1:0] v;
      for (int i = 0; i < N_ROWS; i++) begin
         v[i] = (idx == ROW_W'(i));
      end
      return v;
   endfunction

   // Active-low column drive; built bit by bit so that unused index codes
   // (non power-of-two N_COLS) can never address past the vector.
   function automatic logic [N_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
      logic [N_COLS-1:0] v;
      for (int i = 0; i < N_COLS; i++) begin
         v[i] = (idx != COL_W'(i));
      end
      return v;
   endfunction

   function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] idx);
      if (idx == COL_W'(N_COLS - 1)) begin
         return '0;
      end
      return idx + COL_W'(1);
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t            state_q,     state_d;
   logic [N_ROWS-1:0] sync1_q,     sync1_d;
   logic [N_ROWS-1:0] sync2_q,     sync2_d;
   logic [DIV_W-1:0]  div_q,       div_d;
   logic [COL_W-1:0]  col_q,       col_d;
   logic [ROW_W-1:0]  row_q,       row_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [N_COLS-1:0] cols_q,      cols_d;
   logic [KEY_W-1:0]  key_code_q,  key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_held_q,  key_held_d;
   logic              multi_err_q, multi_err_d;

   logic [N_ROWS-1:0] rs;        // synchronized rows, 1 = pressed
   logic [N_ROWS-1:0] row_oh;    // one-hot of the latched row
   logic [CNT_W-1:0]  cnt_inc;
   logic              row_down;  // latched row still reads pressed
   int                n_hot;

   assign rs       = ~sync2_q;
   assign row_oh   = row_onehot(row_q);
   assign cnt_inc  = sat_inc(cnt_q);
   assign row_down = |(rs & row_oh);
   assign n_hot    = popcount(rs);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      sync1_d     = rows;
      sync2_d     = sync1_q;
      div_d       = div_q;
      col_d       = col_q;
      row_d       = row_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      multi_err_d = 1'b0;

      case (state_q)
         SCAN: begin
            // Rows are only trusted on the last cycle of a slot, by which
            // time the new column has propagated through the synchronizer.
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
               div_d = '0;
               if (n_hot == 1) begin
                  row_d   = onehot_idx(rs);
                  cnt_d   = '0;
                  state_d = DEBOUNCE;
               end else begin
                  multi_err_d = (n_hot > 1);
                  col_d       = next_col(col_q);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         DEBOUNCE: begin
            if (rs == row_oh) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(DEB_CYCLES)) begin
                  cnt_d       = '0;
                  state_d     = HELD;
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  key_code_d  = KEY_W'(int'(row_q) * N_COLS + int'(col_q));
               end
            end else begin
               cnt_d   = '0;
               div_d   = '0;
               col_d   = next_col(col_q);
               state_d = SCAN;
            end
         end

         HELD: begin
            // Only the latched row matters; other keys in this column are ignored.
            if (!row_down) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end

         RELEASE: begin
            if (!row_down) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(DEB_CYCLES)) begin
                  cnt_d      = '0;
                  div_d      = '0;
                  col_d      = next_col(col_q);
                  key_held_d = 1'b0;
                  state_d    = SCAN;
               end
            end else begin
               cnt_d   = '0;
               state_d = HELD;
            end
         end

         default: begin
            state_d = SCAN;
         end
      endcase

      cols_d = col_drive(col_d);
   end

   // ---------------------------------------------------------------------
   // Registers (two-flop row synchronizer feeds the FSM)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         sync1_q     <= '0;
         sync2_q     <= '0;
         div_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         cnt_q       <= '0;
         cols_q      <= col_drive('0);
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         multi_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         div_q       <= div_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cnt_q       <= cnt_d;
         cols_q      <= cols_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         multi_err_q <= multi_err_d;
      end
   end

   assign cols      = cols_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign multi_err = multi_err_q;

endmodule

// File: doc/keypad_scan_decoder.md
KEYPAD_SCAN_DECODER -- requirements
Module: keypad_scan_decoder

Interface
REQ-001 The block SHALL have parameter N_ROWS, default 4, number of keypad rows (2..8).
REQ-002 The block SHALL have parameter N_COLS, default 4, number of keypad columns (2..8).
REQ-003 The block SHALL have parameter SCAN_DIV, default 4, number of clk cycles each column stays driven during scanning (>=3).
REQ-004 The block SHALL have parameter DEB_CYCLES, default 8, number of consecutive stable cycles required for press/release acceptance (>=2).
REQ-005 The block SHALL derive KEY_W = $clog2(N_ROWS*N_COLS) locally; it is not overridable.
REQ-006 The block SHALL have port clk, input, 1, single system clock, rising-edge active.
REQ-007 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port rows, input, N_ROWS, asynchronous keypad row lines, active-low (pulled up).
REQ-009 The block SHALL have port cols, output, N_COLS, column drive, active-low one-hot, registered.
REQ-010 The block SHALL have port key_code, output, KEY_W, last accepted key index.
REQ-011 The block SHALL have port key_valid, output, 1, one-cycle pulse on press acceptance.
REQ-012 The block SHALL have port key_held, output, 1, level, high while an accepted key is held.
REQ-013 The block SHALL have port multi_err, output, 1, one-cycle pulse on a multi-row detection.

Function
REQ-014 rows SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized, inverted value rs (1 = pressed).
REQ-015 The FSM SHALL have states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-016 In SCAN, the column index SHALL advance every SCAN_DIV cycles and wrap N_COLS-1 -> 0; cols SHALL equal ~(1 << index).
REQ-017 In SCAN, rs SHALL be sampled only on the last cycle of each column slot, leaving at least 2 settle cycles for the synchronizer.
REQ-018 If the sample has exactly one bit set, the block SHALL latch the row and column indices, freeze the column, clear the counter, and enter DEBOUNCE.
REQ-019 If the sample has two or more bits set, the block SHALL pulse multi_err for one cycle and continue scanning with no capture.
REQ-020 In DEBOUNCE, each cycle in which rs equals the one-hot of the latched row SHALL increment the counter.
REQ-021 In DEBOUNCE, any other rs value SHALL clear the counter and return to SCAN; scanning resumes at the next column.
REQ-022 When the counter reaches DEB_CYCLES, the block SHALL enter HELD, pulse key_valid on the same cycle that key_code updates to row*N_COLS+col, and set key_held.
REQ-023 In HELD, the column SHALL stay frozen, extra presses in the same column SHALL be ignored, and the block SHALL enter RELEASE with a cleared counter when the latched row bit of rs goes 0.
REQ-024 In RELEASE, each cycle with the latched row bit at 0 SHALL increment the counter; a 1 SHALL return to HELD with no new key_valid.
REQ-025 At DEB_CYCLES in RELEASE, the block SHALL clear key_held, advance the column, and enter SCAN.
REQ-026 Total press latency SHALL be at most 2 + N_COLS*SCAN_DIV + DEB_CYCLES + 1 cycles from a stable pressed row edge to key_valid.
REQ-027 key_code SHALL hold its value between acceptances, and key_valid SHALL fire exactly once per accepted press.
REQ-028 The counter width SHALL be $clog2(DEB_CYCLES+1), and the counter SHALL saturate without wrap.

Reset
REQ-029 When reset=0, the block SHALL immediately and asynchronously force state=SCAN, column index=0, cols=~1, key_code=0, key_valid=0, key_held=0, multi_err=0, counters=0, and synchronizer flops=0.
REQ-030 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL discard the capture; after release, a still-pressed key SHALL be re-detected from SCAN and yield exactly one key_valid.
REQ-031 Outputs SHALL first change on the first rising clk edge after reset deasserts.

Verification
REQ-032 Defaults, hold row 2 low whenever col 1 is driven -> exactly one key_valid, key_code=9, key_held=1 until release plus 8 cycles.
REQ-033 Press row 0/col 0 for a bounce of 5 cycles, then release -> no key_valid; scanning resumes at col 1.
REQ-034 Rows 1 and 3 low during the col 2 slot -> multi_err pulses once per col 2 slot, no key_valid, key_code unchanged.
REQ-035 Hold key 5, glitch its row high for 3 cycles, then release for 8+ cycles -> one key_valid only, and key_held falls once.
REQ-036 Reset pulse while in HELD with key 15 still pressed -> outputs reset values, then one key_valid with key_code=15 after rescan.
REQ-037 With N_ROWS=3, N_COLS=5, SCAN_DIV=3 and no keys, cols SHALL cycle 11110 -> 11101 -> ... -> 01111 -> 11110 every 3 cycles, and pressing row 2/col 4 SHALL give key_code=14.
